// File: rtl/drain_pkg.sv
// Shared types for the result drain controller: FSM state encoding and the
// source-id width helper (clog2 with a floor of one bit).
package drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_WAIT_OUT = 3'd3,
    ST_GUARD    = 3'd4
  } state_t;

  function automatic int sid_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above base, wrapping.
// Zero latency, no backpressure; base must be below NUM_SRC.
module rr_arbiter
  import drain_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SID_W   = sid_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SID_W-1:0]   base,
  output logic [NUM_SRC-1:0] gnt,
  output logic [SID_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(base) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = SID_W'(j);
      end
    end
  end

endmodule

// File: rtl/result_drain_ctrl.sv
// Round-robin drain of NUM_SRC burst buffers onto one valid/ready stream, 3 cycles
// per word (READ, CAPTURE, WAIT_OUT); m_ready low parks the FSM in WAIT_OUT with no reads.
module result_drain_ctrl
  import drain_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_SRC      = 4,
  parameter int BURST        = 4,
  parameter int GUARD_CYCLES = 2,
  localparam int SID_W       = sid_width(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_done,
  output logic [NUM_SRC-1:0]            src_read,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dout,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic [SID_W-1:0]              m_sid,
  output logic                          busy,
  output logic                          err_underrun,
  output logic [15:0]                   burst_cnt
);

  localparam int WCNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int GCNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(BURST - 1);
  localparam logic [GCNT_W-1:0] LAST_GUARD = GCNT_W'(GUARD_CYCLES - 1);
  localparam logic [SID_W-1:0]  LAST_SRC   = SID_W'(NUM_SRC - 1);

  state_t              state, next_state;
  logic [SID_W-1:0]    grant, rr_ptr, arb_idx;
  logic [NUM_SRC-1:0]  grant_oh, arb_gnt;
  logic                arb_any;
  logic [WCNT_W-1:0]   word_cnt;
  logic [GCNT_W-1:0]   guard_cnt;
  logic                grant_done, handshake, guard_exit;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SID_W   (SID_W)
  ) u_arb (
    .req  (src_done),
    .base (rr_ptr),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign grant_done = |(grant_oh & src_done);
  assign handshake  = m_valid && m_ready;
  assign guard_exit = (guard_cnt == LAST_GUARD);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (arb_any) next_state = ST_READ;
      ST_READ:     next_state = grant_done ? ST_CAPTURE : ST_GUARD;
      ST_CAPTURE:  next_state = ST_WAIT_OUT;
      ST_WAIT_OUT: if (handshake) next_state = m_last ? ST_GUARD : ST_READ;
      ST_GUARD:    if (guard_exit) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // The read pulse is gated by the live done flag so an underrun issues no read.
  always_comb begin
    src_read = '0;
    busy     = (state != ST_IDLE);
    if (state == ST_READ) src_read = grant_oh & src_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant        <= '0;
      grant_oh     <= '0;
      rr_ptr       <= '0;
      word_cnt     <= '0;
      guard_cnt    <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_sid        <= '0;
      err_underrun <= 1'b0;
      burst_cnt    <= '0;
    end else begin
      if (state != ST_GUARD) guard_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant    <= arb_idx;
            grant_oh <= arb_gnt;
            word_cnt <= '0;
          end
        end
        ST_READ: begin
          if (!grant_done) err_underrun <= 1'b1;
        end
        ST_CAPTURE: begin
          m_data  <= src_dout[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
          m_sid   <= grant;
          m_last  <= (word_cnt == LAST_WORD);
          m_valid <= 1'b1;
        end
        ST_WAIT_OUT: begin
          if (handshake) begin
            m_valid <= 1'b0;
            if (m_last) burst_cnt <= burst_cnt + 16'd1;
            else        word_cnt  <= word_cnt + 1'b1;
          end
        end
        ST_GUARD: begin
          guard_cnt <= guard_cnt + 1'b1;
          if (guard_exit) rr_ptr <= (grant == LAST_SRC) ? '0 : grant + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain_ctrl.sv
// Directed + randomized bench for result_drain_ctrl with a burst-buffer source model
// and a round-robin scoreboard computed from the arbitration rules.
module tb_result_drain_ctrl;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int B  = 4;
  localparam int G  = 2;
  localparam int SW = 2;

  typedef struct {int cyc; int sid; bit last; logic [DW-1:0] data;} word_t;
  typedef struct {int cyc; int sid;} rd_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NS-1:0]    src_done, src_read;
  logic [NS*DW-1:0] src_dout;
  logic [DW-1:0]    m_data;
  logic             m_valid, m_last, busy, err_underrun;
  logic             m_ready = 1'b0;
  logic [SW-1:0]    m_sid;
  logic [15:0]      burst_cnt;

  int          avail[NS];
  int          nb[NS];
  int          rdn[NS];
  logic [DW-1:0] base[NS];
  logic [DW-1:0] dout[NS];
  int          cyc = 0;
  int          n_chk = 0, n_err = 0;
  int          rd_while_valid = 0, rd_not_onehot = 0, mon_sid = 0;
  bit          rnd_ready = 1'b0;
  word_t       obs[$], exp_q[$];
  rd_t         rdl[$];

  always #5 clk = ~clk;

  result_drain_ctrl #(
    .DATA_WIDTH(DW), .NUM_SRC(NS), .BURST(B), .GUARD_CYCLES(G)
  ) dut (
    .clk(clk), .rst(rst), .src_done(src_done), .src_read(src_read), .src_dout(src_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_sid(m_sid),
    .busy(busy), .err_underrun(err_underrun), .burst_cnt(burst_cnt)
  );

  // Source buffer model: done while unread words remain, data valid the cycle after read.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      src_done[i] = (rdn[i] < avail[i]);
      src_dout[i*DW +: DW] = dout[i];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NS; i++) begin
      if (rst) begin
        rdn[i]  <= 0;
        dout[i] <= '0;
      end else if (src_read[i]) begin
        dout[i] <= base[i] + 32'(rdn[i]);
        rdn[i]  <= rdn[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid && m_ready) obs.push_back('{cyc, int'(m_sid), m_last, m_data});
    if (src_read != '0) begin
      for (int i = 0; i < NS; i++) if (src_read[i]) mon_sid = i;
      rdl.push_back('{cyc, mon_sid});
      if ($countones(src_read) != 1) rd_not_onehot++;
      if (m_valid) rd_while_valid++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    foreach (avail[i]) avail[i] = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Expected output: serve sources with queued bursts in round-robin order from pointer 0.
  task automatic build_exp();
    int rem[NS];
    int ptr, left, s, j;
    ptr = 0;
    left = 0;
    exp_q.delete();
    foreach (nb[i]) begin rem[i] = nb[i]; left += nb[i]; end
    while (left > 0) begin
      s = -1;
      for (int k = 0; k < NS; k++) begin
        j = (ptr + k) % NS;
        if (s < 0 && rem[j] > 0) s = j;
      end
      for (int w = 0; w < B; w++)
        exp_q.push_back('{0, s, (w == B-1), base[s] + 32'((nb[s] - rem[s]) * B + w)});
      rem[s]--;
      left--;
      ptr = (s + 1) % NS;
    end
  endtask

  task automatic load();
    foreach (nb[i]) avail[i] = nb[i] * B;
    build_exp();
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k;
    k = 0;
    step();
    step();
    while ((busy || src_done != '0) && k < max) begin
      step();
      k++;
    end
    chk($sformatf("%s idle", tag), (k < max), 1);
  endtask

  task automatic cmp_stream(input string tag, input int start);
    chk($sformatf("%s count", tag), obs.size() - start, exp_q.size());
    for (int i = 0; i < exp_q.size() && start + i < obs.size(); i++) begin
      chk($sformatf("%s w%0d sid", tag, i), obs[start+i].sid, exp_q[i].sid);
      chk($sformatf("%s w%0d data", tag, i), obs[start+i].data, exp_q[i].data);
      chk($sformatf("%s w%0d last", tag, i), obs[start+i].last, exp_q[i].last);
    end
  endtask

  initial begin
    int o0, r0, rs, k, sum, rv0;
    foreach (avail[i]) begin avail[i] = 0; nb[i] = 0; base[i] = '0; end
    repeat (3) step();
    chk("rst src_read", src_read, 0);
    chk("rst m_valid", m_valid, 0);
    chk("rst m_last", m_last, 0);
    chk("rst m_data", m_data, 0);
    chk("rst m_sid", m_sid, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err_underrun, 0);
    chk("rst burst_cnt", burst_cnt, 0);
    rst = 1'b0;

    // single source 2, words 0xA0..0xA3
    base[2] = 32'hA0;
    nb = '{0, 0, 1, 0};
    m_ready = 1'b1;
    o0 = obs.size(); r0 = rdl.size();
    load();
    wait_idle("single", 200);
    cmp_stream("single", o0);
    chk("single reads", rdl.size() - r0, B);
    for (int i = 0; i < B && r0 + i < rdl.size(); i++) begin
      chk($sformatf("single rd%0d sid", i), rdl[r0+i].sid, 2);
      if (o0 + i < obs.size())
        chk($sformatf("single rd%0d latency", i), obs[o0+i].cyc - rdl[r0+i].cyc, 2);
      if (i > 0) chk($sformatf("single rd%0d gap", i), rdl[r0+i].cyc - rdl[r0+i-1].cyc, 3);
    end
    chk("single burst_cnt", burst_cnt, 1);
    chk("single err", err_underrun, 0);

    // fairness: 0,1,3 with two bursts each
    do_reset();
    base = '{32'h100, 32'h200, 32'h300, 32'h400};
    nb = '{2, 2, 0, 2};
    o0 = obs.size(); r0 = rdl.size();
    load();
    wait_idle("fair", 600);
    cmp_stream("fair", o0);
    chk("fair reads", rdl.size() - r0, 6 * B);
    for (int i = 1; i < 6 * B && r0 + i < rdl.size(); i++)
      chk($sformatf("fair gap%0d", i), rdl[r0+i].cyc - rdl[r0+i-1].cyc, ((i % B) == 0) ? 3 + G + 1 : 3);
    chk("fair burst_cnt", burst_cnt, 6);

    // backpressure on word 2
    do_reset();
    base[1] = 32'h1000;
    nb = '{0, 1, 0, 0};
    o0 = obs.size(); r0 = rdl.size();
    load();
    k = 0;
    while (obs.size() - o0 < 1 && k < 50) begin step(); k++; end
    m_ready = 1'b0;
    k = 0;
    while (!m_valid && k < 10) begin step(); k++; end
    chk("bp valid", m_valid, 1);
    rs = rdl.size();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp hold%0d data", c), m_data, 32'h1001);
      chk($sformatf("bp hold%0d last", c), m_last, 0);
      chk($sformatf("bp hold%0d valid", c), m_valid, 1);
      step();
    end
    chk("bp no read", rdl.size() - rs, 0);
    m_ready = 1'b1;
    wait_idle("bp", 200);
    cmp_stream("bp", o0);
    chk("bp reads", rdl.size() - r0, B);
    chk("bp burst_cnt", burst_cnt, 1);

    // underrun: source 1 drops done after two words
    do_reset();
    base[1] = 32'h500; base[2] = 32'h600;
    nb = '{0, 0, 1, 0};
    o0 = obs.size(); r0 = rdl.size();
    load();
    exp_q.push_front('{0, 1, 1'b0, 32'h501});
    exp_q.push_front('{0, 1, 1'b0, 32'h500});
    avail[1] = 2;
    wait_idle("under", 300);
    cmp_stream("under", o0);
    sum = 0;
    for (int i = r0; i < rdl.size(); i++) if (rdl[i].sid == 1) sum++;
    chk("under src1 reads", sum, 2);
    chk("under err", err_underrun, 1);
    chk("under burst_cnt", burst_cnt, 1);
    repeat (5) step();
    chk("under err sticky", err_underrun, 1);

    // reset during WAIT_OUT with rr pointer advanced
    do_reset();
    base[0] = 32'h800; base[1] = 32'h700; base[3] = 32'h900;
    avail[1] = B;
    wait_idle("pre", 200);
    chk("pre burst_cnt", burst_cnt, 1);
    avail[3] = B;
    m_ready = 1'b0;
    k = 0;
    while (!m_valid && k < 20) begin step(); k++; end
    chk("mid sid", m_sid, 3);
    nb = '{1, 0, 0, 1};
    load();
    rst = 1'b1;
    step();
    chk("mid m_valid", m_valid, 0);
    chk("mid busy", busy, 0);
    chk("mid src_read", src_read, 0);
    chk("mid burst_cnt", burst_cnt, 0);
    rst = 1'b0;
    o0 = obs.size();
    m_ready = 1'b1;
    wait_idle("mid", 300);
    cmp_stream("mid", o0);

    // randomized bursts and backpressure
    rnd_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      do_reset();
      sum = 0;
      for (int i = 0; i < NS; i++) begin
        base[i] = $urandom;
        nb[i] = $urandom_range(0, 3);
        sum += nb[i];
      end
      o0 = obs.size();
      rv0 = rd_while_valid;
      load();
      wait_idle($sformatf("rnd%0d", t), 3000);
      cmp_stream($sformatf("rnd%0d", t), o0);
      chk($sformatf("rnd%0d burst_cnt", t), burst_cnt, sum);
      chk($sformatf("rnd%0d read while held", t), rd_while_valid - rv0, 0);
      chk($sformatf("rnd%0d err", t), err_underrun, 0);
    end
    rnd_ready = 1'b0;
    m_ready = 1'b1;

    // burst counter wrap from preloaded 0xFFFF
    do_reset();
    force dut.burst_cnt = 16'hFFFF;
    step();
    release dut.burst_cnt;
    step();
    chk("wrap preload", burst_cnt, 16'hFFFF);
    base[0] = 32'h40;
    nb = '{1, 0, 0, 0};
    o0 = obs.size();
    load();
    wait_idle("wrap", 200);
    cmp_stream("wrap", o0);
    chk("wrap burst_cnt", burst_cnt, 0);

    chk("read one-hot", rd_not_onehot, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_drain_ctrl.md
# result_drain_ctrl

Round-robin drain controller that shares one downstream result stream between NUM_SRC result buffers of the stream-to-FIFO type, each of which raises `done` when a full burst is parked and hands out one word per `read` pulse. The block picks a ready buffer, issues exactly BURST single-cycle read pulses, and forwards each returned word on a valid/ready output stream tagged with source id and `last`. It sits between the accelerator's per-lane result buffers and the single output FIFO/DMA path.

## Interface
- DATA_WIDTH, 32: result word width.
- NUM_SRC, 4: number of result buffers arbitrated (2..16).
- BURST, 4: words drained per grant; equals the buffers' THRESHOLD.
- GUARD_CYCLES, 2: idle cycles after a burst before re-arbitration (lets the served buffer drop `done`).
- SID_W, max(1, clog2(NUM_SRC)): source-id width (derived localparam).

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- src_done  in  NUM_SRC  per-source "burst parked" flag.
- src_read  out  NUM_SRC  one-hot read pulse to granted source.
- src_dout  in  NUM_SRC*DATA_WIDTH  packed source data; source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_data  out  DATA_WIDTH  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_last  out  1  marks final word of a burst.
- m_sid  out  SID_W  source index of m_data.
- busy  out  1  high in any state except IDLE.
- err_underrun  out  1  sticky: granted source dropped `done` mid-burst.
- burst_cnt  out  16  completed bursts, wraps at 2^16.

## Operation
- States: IDLE, READ, CAPTURE, WAIT_OUT, GUARD.
- IDLE: if any src_done, grant = first set bit searching upward from rr_ptr (wrapping); register grant, word_cnt=0, go READ. Otherwise stay.
- READ: if src_done[grant]=1, src_read[grant]=1 (combinational from state, exactly this cycle), go CAPTURE. If 0: no pulse, set err_underrun, go GUARD.
- CAPTURE: register src_dout[grant] into m_data, m_sid=grant, m_last=(word_cnt==BURST-1), m_valid=1; go WAIT_OUT.
- WAIT_OUT: hold m_data/m_sid/m_last/m_valid stable until m_valid&&m_ready. On handshake: m_valid=0; if m_last, burst_cnt+1 and go GUARD; else word_cnt+1, go READ.
- GUARD: count GUARD_CYCLES cycles, then rr_ptr=(grant+1) mod NUM_SRC, go IDLE. rr_ptr advances on every exit from GUARD, including underrun aborts.
- Requests from non-granted sources are ignored until IDLE; no preemption.
- err_underrun clears only on rst.

## Timing
- Reset: src_read=0, m_valid=0, m_last=0, m_data=0, m_sid=0, busy=0, err_underrun=0, burst_cnt=0, rr_ptr=0, state IDLE. Reset asserted mid-burst aborts at the next edge; no partial word is emitted afterwards.
- Source latency contract: dout valid the cycle after read. READ in cycle N, src_dout sampled at the end of N+1, m_valid high from N+2.
- Per word with m_ready held high: READ, CAPTURE, WAIT_OUT = 3 cycles. Burst = 3*BURST cycles. Grant-to-grant = 1 + 3*BURST + GUARD_CYCLES cycles.
- m_ready low stalls in WAIT_OUT indefinitely. No read is issued while a word is held.
- src_done sampled only in IDLE (arbitration) and READ (underrun check).
- Simultaneous requests: the rr_ptr order is strict. With all sources asserting continuously, grants cycle 0,1,..,NUM_SRC-1,0.

## Structure
- Shared package `drain_pkg`: state enum encoding and the SID_W derivation function (clog2 with min 1).
- One sub-module `rr_arbiter` (NUM_SRC req, base pointer -> one-hot grant + index, combinational). The rest is FSM and counters in the top module.

## Test plan
- Single source: NUM_SRC=4, BURST=4, source 2 done, returns 0xA0..0xA3 with m_ready=1 -> four words with m_sid=2, m_last on 0xA3 only, 4 read pulses each one cycle apart by 3, burst_cnt=1.
- Fairness: sources 0,1,3 done continuously -> grant order 0,1,3,0,1,3; GUARD_CYCLES=2 gap observed between bursts.
- Backpressure: m_ready low 5 cycles on word 2 -> m_data/m_last stable, no src_read during stall, exactly BURST reads total.
- Underrun: source 1 drops done after 2 words -> no third read, err_underrun=1 sticky, burst_cnt unchanged, next grant is source 2.
- Reset mid-burst: rst during WAIT_OUT -> next cycle m_valid=0, busy=0, rr_ptr=0; re-request from source 3 is granted normally.
- Wrap: 65536 bursts (forced counter preload) -> burst_cnt returns to 0.
